parity_stream_unit: RTL and testbench
=====================================

// Module: parity_stream_unit
// PURPOSE
//  Streaming parity generator/checker for DATA_W-bit words with valid/ready flow control.
//  Generalises the 8-bit even-parity/ones-count block: width is a parameter, parity sense is
//  selectable per beat, a received parity bit can be checked, and errors are counted.
//  One registered stage; sits between a word source and a serialiser or link framer.
// PARAMETERS
//  DATA_W   8                     data word width, >= 2
//  CNT_W    $clog2(DATA_W+1)      width of the ones/zeros counts
//  ERR_W    16                    width of the saturating error counter, >= 2
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        asynchronous reset, active-high
//  in_valid    in   1        input beat valid
//  in_ready    out  1        unit can accept a beat this cycle
//  in_data     in   DATA_W   data word
//  in_par      in   1        received parity bit; used only when chk_en=1
//  odd_mode    in   1        0: parity=1 when even number of 1s; 1: parity=1 when odd number of 1s
//  chk_en      in   1        1: compare in_par against generated parity
//  out_valid   out  1        output beat valid
//  out_ready   in   1        downstream accepts output beat
//  out_data    out  DATA_W   registered copy of accepted in_data
//  out_par     out  1        generated parity bit
//  out_count1  out  CNT_W    number of 1s in out_data
//  out_count0  out  CNT_W    number of 0s in out_data (DATA_W - out_count1)
//  out_err     out  1        parity mismatch flag for this beat (0 when chk_en was 0)
//  clr_err     in   1        synchronous clear of err_count
//  err_count   out  ERR_W    saturating count of mismatching accepted beats
// BEHAVIOUR
//  - Reset (async, immediate): out_valid=0, out_data=0, out_par=0, out_count1=0, out_count0=0,
//    out_err=0, err_count=0. A beat held at reset is dropped; no partial state survives.
//  - in_ready = !out_valid || out_ready (combinational; no bubble under continuous flow).
//  - Accept when in_valid && in_ready: on that edge all out_* load; out_valid=1. Latency 1 cycle.
//  - out_valid clears when out_ready=1 and no new beat accepted the same cycle.
//  - While out_valid && !out_ready: all out_* held stable; in_ready=0.
//  - odd_mode, chk_en, in_par sampled only at acceptance; changes between beats affect
//    only subsequently accepted beats.
//  - Parity: P = odd_mode ? ^in_data : ~^in_data. out_count1 = popcount(in_data),
//    out_count0 = DATA_W - out_count1; both exact, never wrap (CNT_W sized for DATA_W).
//  - out_err = chk_en && (in_par != P).
//  - err_count: +1 on acceptance with mismatch; saturates at 2**ERR_W-1 (no wrap).
//    clr_err=1 forces 0 next edge and wins over a simultaneous increment.
//  - No state machine beyond the single valid/hold register; no X on outputs after reset.
// STRUCTURE
//  - parity_pkg: MODE_EVEN=1'b0, MODE_ODD=1'b1 constants; clog2 helper if tool lacks $clog2.
//  - Sub-module parity_popcount (combinational, parameter DATA_W): data -> count1, xor-reduce.
//  - Top: handshake/output register, parity select, mismatch, saturating error counter.
// TESTING (DATA_W=8 unless stated; out_ready=1 unless stated)
//  1. in_data=8'hFF, odd_mode=0, chk_en=0 -> next cycle out_par=1, count1=8, count0=0, out_err=0.
//  2. in_data=8'hAD, odd_mode=0 -> out_par=0, count1=5, count0=3; same word odd_mode=1 -> out_par=1.
//  3. in_data=8'h00, odd_mode=0 -> out_par=1, count1=0, count0=8; back-to-back beats every cycle,
//     in_ready stays 1, outputs in order.
//  4. out_ready=0, send 8'h01 then 8'h03 -> in_ready=0 after first accept, out_data=8'h01 held;
//     out_ready=1 -> 8'h01 then 8'h03 delivered, none lost or duplicated.
//  5. chk_en=1, in_par=1, in_data=8'hAD, odd_mode=0 -> out_err=1, err_count=1; ERR_W=2 with
//     5 bad beats -> err_count=3 held; clr_err with a bad beat same cycle -> err_count=0.
//  6. rst pulsed mid-cycle while out_valid=1, out_ready=0 -> all outputs 0 before next edge;
//     after release first accepted beat behaves as in test 1.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared constants for the parity stream unit: parity-sense encodings and a
// ceiling-log2 helper for tools without $clog2 in constant expressions.
package parity_pkg;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/parity_popcount.sv
// Combinational ones-count and xor-reduction of one data word.
module parity_popcount #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count1,
  output logic              xor_all
);

  // NOTE: every always_comb output gets a default before any conditional or
  // loop update, so no path can leave it unassigned and infer a latch.
  always_comb begin
    count1 = '0;
    for (int i = 0; i < DATA_W; i++) begin
      count1 = count1 + CNT_W'(data[i]);
    end
  end

  assign xor_all = ^data;

endmodule

// File: rtl/parity_stream_unit.sv
// Single-stage streaming parity generator/checker with valid/ready handshake
// and a saturating parity-error counter.
module parity_stream_unit
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1),
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              odd_mode,
  input  logic              chk_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par,
  output logic [CNT_W-1:0]  out_count1,
  output logic [CNT_W-1:0]  out_count0,
  output logic              out_err,
  input  logic              clr_err,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [CNT_W-1:0] DATA_W_C = CNT_W'(DATA_W);

  logic [CNT_W-1:0] count1;
  logic             xor_all;
  logic             par;
  logic             mismatch;
  logic             accept;

  parity_popcount #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_popcount (
    .data    (in_data),
    .count1  (count1),
    .xor_all (xor_all)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign par      = (odd_mode == MODE_ODD) ? xor_all : ~xor_all;
  assign mismatch = chk_en && (in_par != par);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_par    <= 1'b0;
      out_count1 <= '0;
      out_count0 <= '0;
      out_err    <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_data   <= in_data;
      out_par    <= par;
      out_count1 <= count1;
      out_count0 <= DATA_W_C - count1;
      out_err    <= mismatch;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Clear wins over a same-cycle increment; the all-ones value is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (accept && mismatch && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_parity_stream_unit.sv
// Directed bench for parity_stream_unit; a second instance with ERR_W=2
// shares the stimulus to exercise error-counter saturation.
module tb_parity_stream_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_par, odd_mode, chk_en, out_ready, clr_err;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_par, out_err;
  logic [7:0] out_data;
  logic [3:0] out_count1, out_count0;
  logic [15:0] err_count;
  logic       in_ready2, out_valid2, out_par2, out_err2;
  logic [7:0] out_data2;
  logic [3:0] out_count1_2, out_count0_2;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_stream_unit #(.DATA_W(8), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_par(in_par), .odd_mode(odd_mode), .chk_en(chk_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_par(out_par), .out_count1(out_count1),
    .out_count0(out_count0), .out_err(out_err), .clr_err(clr_err), .err_count(err_count)
  );

  parity_stream_unit #(.DATA_W(8), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_par(in_par), .odd_mode(odd_mode), .chk_en(chk_en), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_par(out_par2), .out_count1(out_count1_2),
    .out_count0(out_count0_2), .out_err(out_err2), .clr_err(clr_err), .err_count(err_count2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_data = 0; in_par = 0; odd_mode = 0; chk_en = 0;
    out_ready = 1; clr_err = 0;
    step(); step();
    checks++; if ({out_valid, out_data, out_par, out_count1, out_count0, out_err} !== 19'h0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {out_valid, out_data, out_par, out_count1, out_count0, out_err}); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
    #2 rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_all_ones();
    in_valid = 1; in_data = 8'hFF; odd_mode = 0; chk_en = 0;
    step();
    in_valid = 0;
    checks++; if ({out_valid, out_data, out_par, out_count1, out_count0, out_err} !== {1'b1, 8'hFF, 1'b1, 4'd8, 4'd0, 1'b0}) begin
      errors++; $display("FAIL all_ones got v=%b d=%h p=%b c1=%0d c0=%0d e=%b exp v=1 d=ff p=1 c1=8 c0=0 e=0",
                         out_valid, out_data, out_par, out_count1, out_count0, out_err); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL all_ones_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_modes();
    in_valid = 1; in_data = 8'hAD; odd_mode = 0;
    step();
    checks++; if ({out_par, out_count1, out_count0} !== {1'b0, 4'd5, 4'd3}) begin
      errors++; $display("FAIL ad_even got p=%b c1=%0d c0=%0d exp p=0 c1=5 c0=3", out_par, out_count1, out_count0); end
    odd_mode = 1;
    step();
    in_valid = 0; odd_mode = 0;
    checks++; if ({out_par, out_data} !== {1'b1, 8'hAD}) begin
      errors++; $display("FAIL ad_odd got p=%b d=%h exp p=1 d=ad", out_par, out_data); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3] = '{8'h00, 8'h0F, 8'h7F};
    logic       pars  [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0] ones  [3] = '{4'd0, 4'd4, 4'd7};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = words[i];
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready); end
      step();
      checks++; if ({out_valid, out_data, out_par, out_count1, out_count0} !== {1'b1, words[i], pars[i], ones[i], 4'(8 - ones[i])}) begin
        errors++; $display("FAIL b2b_beat[%0d] got v=%b d=%h p=%b c1=%0d c0=%0d exp d=%h p=%b c1=%0d",
                           i, out_valid, out_data, out_par, out_count1, out_count0, words[i], pars[i], ones[i]); end
    end
    in_valid = 0;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 0; in_valid = 1; in_data = 8'h01;
    step();
    in_data = 8'h03;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", in_ready); end
    step();
    checks++; if ({out_valid, out_data} !== {1'b1, 8'h01}) begin
      errors++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=01", out_valid, out_data); end
    out_ready = 1;
    #1;
    checks++; if ({in_ready, out_data} !== {1'b1, 8'h01}) begin
      errors++; $display("FAIL bp_release got r=%b d=%h exp r=1 d=01", in_ready, out_data); end
    step();
    in_valid = 0;
    checks++; if ({out_valid, out_data, out_count1} !== {1'b1, 8'h03, 4'd2}) begin
      errors++; $display("FAIL bp_second got v=%b d=%h c1=%0d exp v=1 d=03 c1=2", out_valid, out_data, out_count1); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b exp 0", out_valid); end
  endtask

  task automatic test_errors();
    clr_err = 1;
    step();
    clr_err = 0; in_valid = 1; in_data = 8'hAD; odd_mode = 0; chk_en = 1; in_par = 1;
    step();
    checks++; if ({out_err, err_count} !== {1'b1, 16'd1}) begin
      errors++; $display("FAIL err_first got e=%b n=%0d exp e=1 n=1", out_err, err_count); end
    repeat (4) step();
    checks++; if ({err_count, err_count2} !== {16'd5, 2'd3}) begin
      errors++; $display("FAIL err_saturate got n=%0d n2=%0d exp n=5 n2=3", err_count, err_count2); end
    in_par = 0;
    step();
    checks++; if ({out_err, err_count} !== {1'b0, 16'd5}) begin
      errors++; $display("FAIL err_good_beat got e=%b n=%0d exp e=0 n=5", out_err, err_count); end
    in_par = 1; clr_err = 1;
    step();
    clr_err = 0; in_valid = 0; chk_en = 0; in_par = 0;
    checks++; if ({out_err, err_count, err_count2} !== {1'b1, 16'd0, 2'd0}) begin
      errors++; $display("FAIL err_clear_wins got e=%b n=%0d n2=%0d exp e=1 n=0 n2=0", out_err, err_count, err_count2); end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 0; in_valid = 1; in_data = 8'hA5; chk_en = 1; in_par = 1;
    step();
    step();
    in_valid = 0; chk_en = 0; in_par = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre got %b exp 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({out_valid, out_data, out_par, out_count1, out_count0, out_err, err_count} !== 35'h0) begin
      errors++; $display("FAIL ar_immediate got v=%b d=%h p=%b e=%b n=%0d exp all 0",
                         out_valid, out_data, out_par, out_err, err_count); end
    step();
    rst = 1'b0; out_ready = 1;
    step();
    test_all_ones();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_ones();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
